// File: rtl/divider.sv
// Iterative restoring divider for RV64M DIV/REM (+W); one quotient bit per cycle, N+1 cycles, specials in 1.
// Handshake: div_ready level captured in IDLE, held off by busy_o; DIV_EARLY_OUT_EN adds |a|<|b| 1-cycle path.
module divider #(
    parameter int         XLEN      = 64,
    parameter logic [9:0] INST_DIV  = 10'b0110011100,
    parameter logic [9:0] INST_DIVW = 10'b0111011100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_ready,
    input  logic [9:0]      inst_op_f3,
    input  logic [XLEN-1:0] div_op1,
    input  logic [XLEN-1:0] div_op2,
    output logic [XLEN-1:0] div_result,
    output logic            div_finish,
    output logic            busy_o
);

    localparam int HX = XLEN / 2;
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] CNT_X   = CW'(XLEN);
    localparam logic [CW-1:0] CNT_W   = CW'(HX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE,
        S_HOLD
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic            w_q;
    logic            rem_op_q;
    logic            neg_q_q;
    logic            neg_r_q;
    logic [XLEN-1:0] result_q;
    logic            finish_q;
    logic            busy_q;

    logic            in_w;
    logic            in_sg;
    logic            in_rem;
    logic            op_valid;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] min_val;
    logic            b_zero;
    logic            ovf;
    logic            spec_hit;
    logic [XLEN-1:0] spec_res;

    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] trial;
    logic            take;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] fin_res;

    function automatic logic [XLEN-1:0] sext_w(input logic w, input logic [XLEN-1:0] x);
        return w ? {{HX{x[HX-1]}}, x[HX-1:0]} : x;
    endfunction

    // Operands are normalised to XLEN (sign- or zero-extended low half for W-ops) so one datapath serves both widths.
    always_comb begin
        in_w     = (inst_op_f3[9:3] == INST_DIVW[9:3]);
        in_sg    = ~inst_op_f3[0];
        in_rem   = inst_op_f3[1];
        op_valid = inst_op_f3[2] && ((inst_op_f3[9:3] == INST_DIV[9:3]) || in_w);
        a_ext    = in_w ? {{HX{in_sg & div_op1[HX-1]}}, div_op1[HX-1:0]} : div_op1;
        b_ext    = in_w ? {{HX{in_sg & div_op2[HX-1]}}, div_op2[HX-1:0]} : div_op2;
        mag_a    = (in_sg && a_ext[XLEN-1]) ? -a_ext : a_ext;
        mag_b    = (in_sg && b_ext[XLEN-1]) ? -b_ext : b_ext;
        min_val  = in_w ? {{(HX+1){1'b1}}, {(HX-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        b_zero   = (b_ext == '0);
        ovf      = in_sg && (a_ext == min_val) && (b_ext == '1);
    end

    always_comb begin
        spec_hit = 1'b1;
        spec_res = '0;
        if (!op_valid) begin
            spec_res = '0;
        end else if (b_zero) begin
            spec_res = in_rem ? sext_w(in_w, a_ext) : '1;
        end else if (ovf) begin
            spec_res = in_rem ? '0 : sext_w(in_w, a_ext);
`ifdef DIV_EARLY_OUT_EN
        end else if (mag_a < mag_b) begin
            spec_res = in_rem ? sext_w(in_w, a_ext) : '0;
`endif
        end else begin
            spec_hit = 1'b0;
        end
    end

    // When the trial subtract succeeds the difference is below the divisor, so the low XLEN bits are exact.
    always_comb begin
        rem_sh  = {rem_q, quo_q[XLEN-1]};
        trial   = rem_sh[XLEN-1:0] - dvs_q;
        take    = (rem_sh >= {1'b0, dvs_q});
        rem_d   = take ? trial : rem_sh[XLEN-1:0];
        quo_d   = {quo_q[XLEN-2:0], take};
        q_fix   = neg_q_q ? -quo_d : quo_d;
        r_fix   = neg_r_q ? -rem_d : rem_d;
        fin_res = sext_w(w_q, rem_op_q ? r_fix : q_fix);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            w_q      <= 1'b0;
            rem_op_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_ready) begin
                        busy_q <= 1'b1;
                        if (spec_hit) begin
                            result_q <= spec_res;
                            finish_q <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            w_q      <= in_w;
                            rem_op_q <= in_rem;
                            neg_q_q  <= in_sg & (a_ext[XLEN-1] ^ b_ext[XLEN-1]);
                            neg_r_q  <= in_sg & a_ext[XLEN-1];
                            rem_q    <= '0;
                            // W dividends are MSB-aligned so the first shift exposes bit 31.
                            quo_q    <= in_w ? (mag_a << HX) : mag_a;
                            dvs_q    <= mag_b;
                            cnt_q    <= in_w ? CNT_W : CNT_X;
                            state_q  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        result_q <= fin_res;
                        finish_q <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    finish_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= div_ready ? S_HOLD : S_IDLE;
                end
                S_HOLD: begin
                    if (!div_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign div_result = result_q;
    assign div_finish = finish_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_divider.sv
// Bench for divider: table-driven and random ops checked against a queue of expected results and latencies.
module tb_divider;

    localparam logic [9:0] OP_DIV   = 10'b0110011100;
    localparam logic [9:0] OP_DIVU  = 10'b0110011101;
    localparam logic [9:0] OP_REM   = 10'b0110011110;
    localparam logic [9:0] OP_REMU  = 10'b0110011111;
    localparam logic [9:0] OP_DIVW  = 10'b0111011100;
    localparam logic [9:0] OP_DIVUW = 10'b0111011101;
    localparam logic [9:0] OP_REMW  = 10'b0111011110;
    localparam logic [9:0] OP_REMUW = 10'b0111011111;
`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [9:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_ready;
    logic [9:0]  inst_op_f3;
    logic [63:0] div_op1;
    logic [63:0] div_op2;
    logic [63:0] div_result;
    logic        div_finish;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_res_q[$];
    int          exp_lat_q[$];

    always #5 clk = ~clk;

    divider dut (
        .clk       (clk),
        .rst       (rst),
        .div_ready (div_ready),
        .inst_op_f3(inst_op_f3),
        .div_op1   (div_op1),
        .div_op2   (div_op2),
        .div_result(div_result),
        .div_finish(div_finish),
        .busy_o    (busy_o)
    );

    // Independent reference built on native SV division.
    function automatic void model(input logic [9:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output int lat);
        logic               w;
        logic               sg;
        logic               rm;
        logic signed [31:0] a32;
        logic signed [31:0] b32;
        logic [31:0]        r32;
        logic signed [63:0] as;
        logic signed [63:0] bs;
        logic [63:0]        ma;
        logic [63:0]        mb;
        w  = (op[9:3] == 7'b0111011);
        sg = !op[0];
        rm = op[1];
        r  = '0;
        lat = 1;
        if (!op[2] || !((op[9:3] == 7'b0110011) || w)) return;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0) begin
                r32 = rm ? a32 : 32'hFFFFFFFF;
            end else if (sg && a32 == 32'sh80000000 && b32 == -32'sd1) begin
                r32 = rm ? 32'h0 : a32;
            end else begin
                if (sg) r32 = rm ? a32 % b32 : a32 / b32;
                else    r32 = rm ? $unsigned(a32) % $unsigned(b32) : $unsigned(a32) / $unsigned(b32);
                ma  = {32'h0, (sg && a32[31]) ? 32'(-a32) : a32};
                mb  = {32'h0, (sg && b32[31]) ? 32'(-b32) : b32};
                lat = (EARLY && ma < mb) ? 1 : 33;
            end
            r = {{32{r32[31]}}, r32};
        end else begin
            as = a;
            bs = b;
            if (bs == 0) begin
                r = rm ? a : '1;
            end else if (sg && as == 64'sh8000000000000000 && bs == -64'sd1) begin
                r = rm ? '0 : a;
            end else begin
                if (sg) r = rm ? as % bs : as / bs;
                else    r = rm ? a % b : a / b;
                ma  = (sg && as[63]) ? -a : a;
                mb  = (sg && bs[63]) ? -b : b;
                lat = (EARLY && ma < mb) ? 1 : 65;
            end
        end
    endfunction

    task automatic issue(input logic [9:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        div_ready  = 1'b1;
        inst_op_f3 = op;
        div_op1    = a;
        div_op2    = b;
        @(posedge clk);
        #1;
        inst_op_f3 = 10'($urandom);
        div_op1    = {$urandom, $urandom};
        div_op2    = {$urandom, $urandom};
    endtask

    task automatic collect(input bit keep, output logic [63:0] res, output int lat,
                           output bit busy_ok, output bit tmo);
        res = '0;
        lat = 0;
        busy_ok = 1'b1;
        tmo = 1'b1;
        while (tmo && lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            if (div_finish === 1'b1) begin
                res = div_result;
                tmo = 1'b0;
            end
        end
        if (!keep) div_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        div_ready = 1'b0;
        inst_op_f3 = '0;
        div_op1 = '0;
        div_op2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || div_finish !== 1'b0 || div_result !== 64'h0) begin
            failures++;
            $display("FAIL reset got busy=%b fin=%b res=%h want 0/0/0", busy_o, div_finish, div_result);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || div_finish !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b fin=%b want 0/0", busy_o, div_finish);
        end
    endtask

    task automatic test_unsigned();
        vec_t v[$];
        logic [63:0] res, er;
        int lat, el;
        bit bok, tmo;
        v.push_back('{OP_DIVU, 64'd100, 64'd7, 64'd14, 65});
        v.push_back('{OP_REMU, 64'd100, 64'd7, 64'd2, 65});
        foreach (v[i]) begin
            exp_res_q.push_back(v[i].r);
            exp_lat_q.push_back(v[i].lat);
            issue(v[i].op, v[i].a, v[i].b);
            collect(1'b0, res, lat, bok, tmo);
            er = exp_res_q.pop_front();
            el = exp_lat_q.pop_front();
            checks++;
            if (tmo || res !== er) begin failures++; $display("FAIL unsigned[%0d] result got=%h want=%h", i, res, er); end
            checks++;
            if (lat != el) begin failures++; $display("FAIL unsigned[%0d] latency got=%0d want=%0d", i, lat, el); end
            checks++;
            if (!bok) begin failures++; $display("FAIL unsigned[%0d] busy got=0 want=1 throughout", i); end
        end
    endtask

    task automatic test_signed();
        vec_t v[$];
        logic [63:0] res, er;
        int lat, el;
        bit bok, tmo;
        v.push_back('{OP_DIV, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 65});
        v.push_back('{OP_REM, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65});
        v.push_back('{OP_REM, 64'd7, 64'hFFFFFFFFFFFFFFFE, 64'd1, 65});
        v.push_back('{OP_DIV, 64'd7, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFD, 65});
        foreach (v[i]) begin
            exp_res_q.push_back(v[i].r);
            exp_lat_q.push_back(v[i].lat);
            issue(v[i].op, v[i].a, v[i].b);
            collect(1'b0, res, lat, bok, tmo);
            er = exp_res_q.pop_front();
            el = exp_lat_q.pop_front();
            checks++;
            if (tmo || res !== er) begin failures++; $display("FAIL signed[%0d] result got=%h want=%h", i, res, er); end
            checks++;
            if (lat != el) begin failures++; $display("FAIL signed[%0d] latency got=%0d want=%0d", i, lat, el); end
        end
    endtask

    task automatic test_special();
        vec_t v[$];
        logic [63:0] res, er;
        int lat, el;
        bit bok, tmo;
        v.push_back('{OP_DIV, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1});
        v.push_back('{OP_REM, 64'd5, 64'd0, 64'd5, 1});
        v.push_back('{OP_DIV, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1});
        v.push_back('{OP_REM, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1});
        v.push_back('{OP_DIVU, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0, EARLY ? 1 : 65});
        v.push_back('{OP_DIV, 64'h8000000000000000, 64'h1, 64'h8000000000000000, 65});
        v.push_back('{10'b0110011000, 64'd100, 64'd7, 64'h0, 1});
        foreach (v[i]) begin
            exp_res_q.push_back(v[i].r);
            exp_lat_q.push_back(v[i].lat);
            issue(v[i].op, v[i].a, v[i].b);
            collect(1'b0, res, lat, bok, tmo);
            er = exp_res_q.pop_front();
            el = exp_lat_q.pop_front();
            checks++;
            if (tmo || res !== er) begin failures++; $display("FAIL special[%0d] result got=%h want=%h", i, res, er); end
            checks++;
            if (lat != el) begin failures++; $display("FAIL special[%0d] latency got=%0d want=%0d", i, lat, el); end
        end
    endtask

    task automatic test_word();
        vec_t v[$];
        logic [63:0] res, er;
        int lat, el;
        bit bok, tmo;
        v.push_back('{OP_DIVW, 64'h0000000180000000, 64'd1, 64'hFFFFFFFF80000000, 33});
        v.push_back('{OP_DIVUW, 64'h00000000FFFFFFFF, 64'd1, 64'hFFFFFFFFFFFFFFFF, 33});
        v.push_back('{OP_REMW, 64'hDEAD000012345678, 64'hFFFFFFFF00000000, 64'h0000000012345678, 1});
        v.push_back('{OP_DIVW, 64'hABCD0000FFFFFFF9, 64'h1234000000000002, 64'hFFFFFFFFFFFFFFFD, 33});
        v.push_back('{OP_REMUW, 64'h00000000FFFFFFFF, 64'd16, 64'h000000000000000F, 33});
        v.push_back('{OP_DIVW, 64'h0000000080000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000, 1});
        foreach (v[i]) begin
            exp_res_q.push_back(v[i].r);
            exp_lat_q.push_back(v[i].lat);
            issue(v[i].op, v[i].a, v[i].b);
            collect(1'b0, res, lat, bok, tmo);
            er = exp_res_q.pop_front();
            el = exp_lat_q.pop_front();
            checks++;
            if (tmo || res !== er) begin failures++; $display("FAIL word[%0d] result got=%h want=%h", i, res, er); end
            checks++;
            if (lat != el) begin failures++; $display("FAIL word[%0d] latency got=%0d want=%0d", i, lat, el); end
        end
    endtask

    task automatic test_early();
        vec_t v[$];
        logic [63:0] res, er;
        int lat, el;
        bit bok, tmo;
        v.push_back('{OP_DIVU, 64'd3, 64'd10, 64'd0, EARLY ? 1 : 65});
        v.push_back('{OP_REMU, 64'd3, 64'd10, 64'd3, EARLY ? 1 : 65});
        v.push_back('{OP_REM, 64'hFFFFFFFFFFFFFFFD, 64'd10, 64'hFFFFFFFFFFFFFFFD, EARLY ? 1 : 65});
        v.push_back('{OP_DIVW, 64'h00000000FFFFFFFD, 64'd10, 64'd0, EARLY ? 1 : 33});
        foreach (v[i]) begin
            exp_res_q.push_back(v[i].r);
            exp_lat_q.push_back(v[i].lat);
            issue(v[i].op, v[i].a, v[i].b);
            collect(1'b0, res, lat, bok, tmo);
            er = exp_res_q.pop_front();
            el = exp_lat_q.pop_front();
            checks++;
            if (tmo || res !== er) begin failures++; $display("FAIL early[%0d] result got=%h want=%h", i, res, er); end
            checks++;
            if (lat != el) begin failures++; $display("FAIL early[%0d] latency got=%0d want=%0d", i, lat, el); end
        end
    endtask

    task automatic test_hold();
        logic [63:0] res, er;
        int lat, el, extra;
        bit bok, tmo;
        exp_res_q.push_back(64'd100);
        exp_lat_q.push_back(65);
        issue(OP_DIVU, 64'd1000, 64'd10);
        collect(1'b1, res, lat, bok, tmo);
        er = exp_res_q.pop_front();
        el = exp_lat_q.pop_front();
        checks++;
        if (tmo || res !== er) begin failures++; $display("FAIL hold_first result got=%h want=%h", res, er); end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (div_finish !== 1'b0 || busy_o !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin failures++; $display("FAIL hold_no_reissue got=%0d active cycles want=0", extra); end
        div_ready = 1'b0;
        exp_res_q.push_back(64'd6);
        exp_lat_q.push_back(65);
        issue(OP_REMU, 64'd1000, 64'd7);
        collect(1'b0, res, lat, bok, tmo);
        er = exp_res_q.pop_front();
        el = exp_lat_q.pop_front();
        checks++;
        if (tmo || res !== er || lat != el) begin
            failures++;
            $display("FAIL hold_rearm got=%h lat=%0d want=%h lat=%0d", res, lat, er, el);
        end
    endtask

    task automatic test_rst_mid();
        logic [63:0] res, er;
        int lat, el;
        bit bok, tmo;
        issue(OP_DIVU, 64'hFFFFFFFFFFFFFFFF, 64'd3);
        repeat (20) @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b want=1", busy_o); end
        rst = 1'b1;
        div_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || div_finish !== 1'b0 || div_result !== 64'h0) begin
            failures++;
            $display("FAIL rst_mid got busy=%b fin=%b res=%h want 0/0/0", busy_o, div_finish, div_result);
        end
        exp_res_q.push_back(64'd14);
        exp_lat_q.push_back(65);
        issue(OP_DIVU, 64'd100, 64'd7);
        collect(1'b0, res, lat, bok, tmo);
        er = exp_res_q.pop_front();
        el = exp_lat_q.pop_front();
        checks++;
        if (tmo || res !== er || lat != el) begin
            failures++;
            $display("FAIL rst_mid_recover got=%h lat=%0d want=%h lat=%0d", res, lat, er, el);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  ops[8] = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
        logic [9:0]  op;
        logic [63:0] a, b, mr, res, er;
        int ml, lat, el;
        bit bok, tmo;
        for (int n = 0; n < 16; n++) begin
            op = ops[$urandom_range(0, 7)];
            a  = {$urandom, $urandom} >> $urandom_range(0, 63);
            b  = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 1) == 1) b = -b;
            if ($urandom_range(0, 7) == 0) b = '0;
            model(op, a, b, mr, ml);
            exp_res_q.push_back(mr);
            exp_lat_q.push_back(ml);
            issue(op, a, b);
            collect(1'b0, res, lat, bok, tmo);
            er = exp_res_q.pop_front();
            el = exp_lat_q.pop_front();
            checks++;
            if (tmo || res !== er || lat != el) begin
                failures++;
                $display("FAIL b2b[%0d] op=%b a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                         n, op, a, b, res, lat, er, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_word();
        test_early();
        test_hold();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
